// File: rtl/pos_remote_input_arbiter_if.sv
// Signal bundle between the remote-input arbiter, the per-FPGA receive FIFOs,
// the ring's external node and the outbound remote TX FIFO occupancy.
// The master modport is the arbiter side; the slave modport is the surrounding fabric.
// Defining POS_REMOTE_ARB_STATS_EN adds the statistics counter outputs.
interface pos_remote_input_arbiter_if #(
  parameter int NUM_SRC = 7,
  parameter int PKT_W   = 39,
  parameter int GCID_W  = 9,
  parameter int LIFE_W  = 4,
  parameter int CNT_W   = 8
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        i_src_valid;
  logic [NUM_SRC*PKT_W-1:0]  i_src_offset_pkt;
  logic [NUM_SRC*GCID_W-1:0] i_src_gcid;
  logic [NUM_SRC*LIFE_W-1:0] i_src_lifetime;
  logic [NUM_SRC-1:0]        o_src_rd;

  logic                      o_remote_valid;
  logic [PKT_W-1:0]          o_remote_offset_pkt;
  logic [GCID_W-1:0]         o_remote_gcid;
  logic [LIFE_W-1:0]         o_remote_lifetime;
  logic [SRC_W-1:0]          o_remote_src_id;
  logic                      i_remote_ack;

  logic [CNT_W-1:0]          i_tx_fifo_count;
  logic                      o_remote_buffer_back_pressure;

`ifdef POS_REMOTE_ARB_STATS_EN
  logic [NUM_SRC*32-1:0]     o_grant_cnt;
  logic [31:0]               o_drop_cnt;
  logic [31:0]               o_stall_cycles;
`endif

  modport master (
    input  i_src_valid, i_src_offset_pkt, i_src_gcid, i_src_lifetime,
    input  i_remote_ack, i_tx_fifo_count,
`ifdef POS_REMOTE_ARB_STATS_EN
    output o_grant_cnt, o_drop_cnt, o_stall_cycles,
`endif
    output o_src_rd, o_remote_valid, o_remote_offset_pkt, o_remote_gcid,
    output o_remote_lifetime, o_remote_src_id, o_remote_buffer_back_pressure
  );

  modport slave (
    output i_src_valid, i_src_offset_pkt, i_src_gcid, i_src_lifetime,
    output i_remote_ack, i_tx_fifo_count,
`ifdef POS_REMOTE_ARB_STATS_EN
    input  o_grant_cnt, o_drop_cnt, o_stall_cycles,
`endif
    input  o_src_rd, o_remote_valid, o_remote_offset_pkt, o_remote_gcid,
    input  o_remote_lifetime, o_remote_src_id, o_remote_buffer_back_pressure
  );
endinterface

// File: rtl/pos_remote_input_arbiter.sv
// Round-robin scheduler for the remote-input port of the position ring's ext node.
// Pulls packets from NUM_SRC FWFT receive FIFOs, holds one packet until the node acks,
// silently discards zero-lifetime heads, and drives a hysteretic back-pressure flag
// derived from the outbound remote TX FIFO occupancy (BP_LO must be below BP_HI).
// Optional statistics counters are built when POS_REMOTE_ARB_STATS_EN is defined.
// gcid is passed through untouched; frame conversion happens in the ext node.
module pos_remote_input_arbiter #(
  parameter int NUM_SRC = 7,
  parameter int PKT_W   = 39,
  parameter int GCID_W  = 9,
  parameter int LIFE_W  = 4,
  parameter int CNT_W   = 8,
  parameter int BP_HI   = 200,
  parameter int BP_LO   = 128
) (
  input logic                        clk,
  input logic                        rst,
  pos_remote_input_arbiter_if.master bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PKT_W-1:0]    pkt_q, pkt_d;
  logic [GCID_W-1:0]   gcid_q, gcid_d;
  logic [LIFE_W-1:0]   life_q, life_d;
  logic [SRC_W-1:0]    src_id_q, src_id_d;
  logic                bp_q, bp_d;

  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  zero_life;
  logic [NUM_SRC-1:0]  src_rd;
  logic                grant_vld;
  logic [SRC_W-1:0]    grant_idx;
  logic [PKT_W-1:0]    sel_pkt;
  logic [GCID_W-1:0]   sel_gcid;
  logic [LIFE_W-1:0]   sel_life;
  logic                load;

  // Split each valid FIFO head into presentable packets and zero-lifetime discards
  always_comb begin
    eligible  = '0;
    zero_life = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.i_src_valid[k]) begin
        if (bus.i_src_lifetime[k*LIFE_W +: LIFE_W] == '0) begin
          zero_life[k] = 1'b1;
        end else begin
          eligible[k] = 1'b1;
        end
      end
    end
  end

  // Round-robin search starting just after the last granted source
  always_comb begin
    logic [SRC_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = SRC_W'((int'(rr_ptr_q) + i) % NUM_SRC);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the head packet of the granted source
  always_comb begin
    sel_pkt  = '0;
    sel_gcid = '0;
    sel_life = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_idx == SRC_W'(k)) begin
        sel_pkt  = bus.i_src_offset_pkt[k*PKT_W +: PKT_W];
        sel_gcid = bus.i_src_gcid[k*GCID_W +: GCID_W];
        sel_life = bus.i_src_lifetime[k*LIFE_W +: LIFE_W];
      end
    end
  end

  // A new packet may be taken when nothing is held or the held one is being accepted
  assign load = (state_q == IDLE) || bus.i_remote_ack;

  // Next state, hold-register contents and FIFO pop pulses
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    pkt_d    = pkt_q;
    gcid_d   = gcid_q;
    life_d   = life_q;
    src_id_d = src_id_q;
    src_rd   = '0;
    if (load) begin
      src_rd = zero_life;
      if (grant_vld) begin
        src_rd[grant_idx] = 1'b1;
        state_d           = HOLD;
        rr_ptr_d          = grant_idx;
        pkt_d             = sel_pkt;
        gcid_d            = sel_gcid;
        life_d            = sel_life;
        src_id_d          = grant_idx;
      end else begin
        state_d  = IDLE;
        pkt_d    = '0;
        gcid_d   = '0;
        life_d   = '0;
        src_id_d = '0;
      end
    end
    if (rst) begin
      src_rd = '0;
    end
  end

  // State, round-robin pointer and held packet registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= SRC_W'(NUM_SRC - 1);
      pkt_q    <= '0;
      gcid_q   <= '0;
      life_q   <= '0;
      src_id_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      pkt_q    <= pkt_d;
      gcid_q   <= gcid_d;
      life_q   <= life_d;
      src_id_q <= src_id_d;
    end
  end

  // Hysteresis band: set at the high mark, clear at the low mark, hold in between
  always_comb begin
    bp_d = bp_q;
    if (bus.i_tx_fifo_count >= CNT_W'(BP_HI)) begin
      bp_d = 1'b1;
    end else if (bus.i_tx_fifo_count <= CNT_W'(BP_LO)) begin
      bp_d = 1'b0;
    end
  end

  // Back-pressure flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q <= 1'b0;
    end else begin
      bp_q <= bp_d;
    end
  end

  assign bus.o_src_rd                      = src_rd;
  assign bus.o_remote_valid                = (state_q == HOLD);
  assign bus.o_remote_offset_pkt           = pkt_q;
  assign bus.o_remote_gcid                 = gcid_q;
  assign bus.o_remote_lifetime             = life_q;
  assign bus.o_remote_src_id               = src_id_q;
  assign bus.o_remote_buffer_back_pressure = bp_q;

`ifdef POS_REMOTE_ARB_STATS_EN
  logic [NUM_SRC*32-1:0] grant_cnt_q;
  logic [31:0]           drop_cnt_q;
  logic [31:0]           stall_q;
  logic [31:0]           drop_inc;

  // Number of zero-lifetime heads discarded this cycle
  always_comb begin
    drop_inc = '0;
    if (load) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        drop_inc = drop_inc + 32'(zero_life[k]);
      end
    end
  end

  // Per-source grant, discard and stalled-hold counters (all wrap naturally)
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      drop_cnt_q  <= '0;
      stall_q     <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (load && grant_vld && (grant_idx == SRC_W'(k))) begin
          grant_cnt_q[k*32 +: 32] <= grant_cnt_q[k*32 +: 32] + 32'd1;
        end
      end
      drop_cnt_q <= drop_cnt_q + drop_inc;
      if ((state_q == HOLD) && !bus.i_remote_ack) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign bus.o_grant_cnt    = grant_cnt_q;
  assign bus.o_drop_cnt     = drop_cnt_q;
  assign bus.o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pos_remote_input_arbiter.sv
// Self-checking bench for pos_remote_input_arbiter.
// Source FIFOs are modelled as queues; a packet-level reference model predicts pops,
// the held packet, back-pressure and (with POS_REMOTE_ARB_STATS_EN) the counters.
module tb_pos_remote_input_arbiter;
  localparam int NUM_SRC = 7;
  localparam int PKT_W   = 39;
  localparam int GCID_W  = 9;
  localparam int LIFE_W  = 4;
  localparam int CNT_W   = 8;
  localparam int BP_HI   = 200;
  localparam int BP_LO   = 128;

  typedef struct packed {
    logic [PKT_W-1:0]  pkt;
    logic [GCID_W-1:0] gcid;
    logic [LIFE_W-1:0] life;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pos_remote_input_arbiter_if #(
    .NUM_SRC(NUM_SRC), .PKT_W(PKT_W), .GCID_W(GCID_W), .LIFE_W(LIFE_W), .CNT_W(CNT_W)
  ) bus ();

  pos_remote_input_arbiter #(
    .NUM_SRC(NUM_SRC), .PKT_W(PKT_W), .GCID_W(GCID_W), .LIFE_W(LIFE_W),
    .CNT_W(CNT_W), .BP_HI(BP_HI), .BP_LO(BP_LO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pkt_t fifo_q [NUM_SRC][$];
  pkt_t sb_q   [NUM_SRC][$];

  int pass_cnt = 0;
  int fail_cnt = 0;

  logic              m_valid = 1'b0;
  logic [PKT_W-1:0]  m_pkt   = '0;
  logic [GCID_W-1:0] m_gcid  = '0;
  logic [LIFE_W-1:0] m_life  = '0;
  int                m_src   = 0;
  int                m_last  = NUM_SRC - 1;
  logic              m_bp    = 1'b0;
  logic [31:0]       m_grant [NUM_SRC];
  logic [31:0]       m_drop  = '0;
  logic [31:0]       m_stall = '0;
  int                wait_acks [NUM_SRC];

  logic              cur_rst;
  logic              cur_ack;
  logic [CNT_W-1:0]  cur_cnt;
  logic [NUM_SRC-1:0] obs_rd;
  logic              obs_valid;
  logic [PKT_W-1:0]  obs_pkt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int k, input logic [LIFE_W-1:0] life);
    pkt_t p;
    p.pkt  = PKT_W'({$urandom(), $urandom()});
    p.gcid = GCID_W'($urandom());
    p.life = life;
    fifo_q[k].push_back(p);
    if (life != '0) sb_q[k].push_back(p);
  endtask

  task automatic applyStimulus(input logic rst_v, input logic ack_v, input logic [CNT_W-1:0] cnt_v);
    logic [NUM_SRC-1:0]        v;
    logic [NUM_SRC*PKT_W-1:0]  pk;
    logic [NUM_SRC*GCID_W-1:0] gc;
    logic [NUM_SRC*LIFE_W-1:0] lf;
    v = '0; pk = '0; gc = '0; lf = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (fifo_q[k].size() > 0) begin
        v[k] = 1'b1;
        pk[k*PKT_W +: PKT_W]   = fifo_q[k][0].pkt;
        gc[k*GCID_W +: GCID_W] = fifo_q[k][0].gcid;
        lf[k*LIFE_W +: LIFE_W] = fifo_q[k][0].life;
      end
    end
    bus.i_src_valid      = v;
    bus.i_src_offset_pkt = pk;
    bus.i_src_gcid       = gc;
    bus.i_src_lifetime   = lf;
    bus.i_remote_ack     = ack_v;
    bus.i_tx_fifo_count  = cnt_v;
    rst     = rst_v;
    cur_rst = rst_v;
    cur_ack = ack_v;
    cur_cnt = cnt_v;
  endtask

  function automatic int model_grant();
    int c;
    for (int i = 1; i <= NUM_SRC; i++) begin
      c = (m_last + i) % NUM_SRC;
      if (fifo_q[c].size() > 0 && fifo_q[c][0].life != '0) return c;
    end
    return -1;
  endfunction

  task automatic checkOutput();
    logic [NUM_SRC-1:0] exp_rd;
    int g;
    exp_rd = '0;
    if (!cur_rst && (!m_valid || cur_ack)) begin
      g = model_grant();
      if (g >= 0) exp_rd[g] = 1'b1;
      for (int k = 0; k < NUM_SRC; k++)
        if (fifo_q[k].size() > 0 && fifo_q[k][0].life == '0) exp_rd[k] = 1'b1;
    end
    obs_rd    = bus.o_src_rd;
    obs_valid = bus.o_remote_valid;
    obs_pkt   = bus.o_remote_offset_pkt;
    chk("src_rd",   64'(bus.o_src_rd),            64'(exp_rd));
    chk("valid",    64'(bus.o_remote_valid),      64'(m_valid));
    chk("pkt",      64'(bus.o_remote_offset_pkt), 64'(m_pkt));
    chk("gcid",     64'(bus.o_remote_gcid),       64'(m_gcid));
    chk("lifetime", 64'(bus.o_remote_lifetime),   64'(m_life));
    chk("src_id",   64'(bus.o_remote_src_id),     64'(m_src));
    chk("back_pressure", 64'(bus.o_remote_buffer_back_pressure), 64'(m_bp));
`ifdef POS_REMOTE_ARB_STATS_EN
    for (int k = 0; k < NUM_SRC; k++)
      chk("grant_cnt", 64'(bus.o_grant_cnt[k*32 +: 32]), 64'(m_grant[k]));
    chk("drop_cnt",     64'(bus.o_drop_cnt),     64'(m_drop));
    chk("stall_cycles", 64'(bus.o_stall_cycles), 64'(m_stall));
`endif
  endtask

  task automatic modelUpdate();
    int g;
    if (cur_rst) begin
      if (m_valid && sb_q[m_src].size() > 0) void'(sb_q[m_src].pop_front());
      m_valid = 1'b0; m_pkt = '0; m_gcid = '0; m_life = '0; m_src = 0;
      m_last = NUM_SRC - 1; m_bp = 1'b0; m_drop = '0; m_stall = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        m_grant[k] = '0;
        wait_acks[k] = 0;
      end
    end else begin
      if (cur_cnt >= BP_HI) m_bp = 1'b1;
      else if (cur_cnt <= BP_LO) m_bp = 1'b0;
      if (m_valid && !cur_ack) m_stall++;
      if (m_valid && cur_ack && sb_q[m_src].size() > 0) begin
        chk("fifo_order", 64'(obs_pkt), 64'(sb_q[m_src][0].pkt));
        void'(sb_q[m_src].pop_front());
      end
      if (!m_valid || cur_ack) begin
        g = model_grant();
        for (int k = 0; k < NUM_SRC; k++) begin
          if (fifo_q[k].size() > 0 && fifo_q[k][0].life == '0) begin
            m_drop++;
            wait_acks[k] = 0;
          end else if (fifo_q[k].size() > 0) begin
            if (obs_rd[k]) begin
              chk("no_starvation", 64'(wait_acks[k] <= NUM_SRC), 64'(1));
              wait_acks[k] = 0;
            end else begin
              wait_acks[k]++;
            end
          end else begin
            wait_acks[k] = 0;
          end
        end
        if (g >= 0) begin
          m_valid = 1'b1;
          m_pkt   = fifo_q[g][0].pkt;
          m_gcid  = fifo_q[g][0].gcid;
          m_life  = fifo_q[g][0].life;
          m_src   = g;
          m_last  = g;
          m_grant[g]++;
        end else begin
          m_valid = 1'b0; m_pkt = '0; m_gcid = '0; m_life = '0; m_src = 0;
        end
      end
    end
    for (int k = 0; k < NUM_SRC; k++)
      if (obs_rd[k] && fifo_q[k].size() > 0) void'(fifo_q[k].pop_front());
  endtask

  task automatic cycle(input logic rst_v, input logic ack_v, input logic [CNT_W-1:0] cnt_v);
    applyStimulus(rst_v, ack_v, cnt_v);
    @(negedge clk);
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vcount;
    int pops2;
    for (int k = 0; k < NUM_SRC; k++) begin
      m_grant[k] = '0;
      wait_acks[k] = 0;
    end

    $display("[TB] reset");
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);

    $display("[TB] round robin over sources 0, 3, 5 with continuous ack");
    for (int n = 0; n < 4; n++) begin
      push_pkt(0, 4'd4);
      push_pkt(3, 4'd4);
      push_pkt(5, 4'd4);
    end
    for (int n = 0; n < 15; n++) cycle(1'b0, 1'b1, '0);

    $display("[TB] hold source 2 for ten cycles without ack");
    push_pkt(2, 4'd7);
    vcount = 0;
    pops2  = 0;
    for (int n = 0; n < 13; n++) begin
      cycle(1'b0, (n == 11), '0);
      vcount += int'(obs_valid);
      pops2  += int'(obs_rd[2]);
    end
    chk("hold_valid_cycles", 64'(vcount), 64'(11));
    chk("hold_pop_count",    64'(pops2),  64'(1));

    $display("[TB] zero-lifetime head on source 4");
    push_pkt(4, 4'd0);
    push_pkt(4, 4'd3);
    for (int n = 0; n < 4; n++) cycle(1'b0, 1'b1, '0);

    $display("[TB] back-pressure ramp");
    for (int c = 0; c <= 255; c++) cycle(1'b0, 1'b0, CNT_W'(c));
    for (int c = 254; c >= 0; c--) cycle(1'b0, 1'b0, CNT_W'(c));

    $display("[TB] reset while holding source 6");
    push_pkt(6, 4'd5);
    push_pkt(6, 4'd5);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    $display("[TB] random traffic on all sources");
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NUM_SRC; k++)
        while (fifo_q[k].size() < 3)
          push_pkt(k, ($urandom_range(0, 7) == 0) ? 4'd0 : LIFE_W'($urandom_range(1, 15)));
      cycle(1'b0, 1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end
endmodule

// File: doc/pos_remote_input_arbiter.md
Name: pos_remote_input_arbiter

Overview:
- Round-robin scheduler feeding the remote-input port of the position ring's external node.
- Collects position packets from NUM_SRC first-word-fall-through (FWFT) receive FIFOs, one per remote FPGA. Presents one packet at a time to the ext node and holds it until the node acks.
- Also generates the registered, hysteretic back-pressure flag the ext node uses to stop diverting packets into the outbound remote TX buffer.

Parameters:
- NUM_SRC, 7, number of remote source FIFOs (remote nodes in a 2x2x2 system).
- PKT_W, OFFSET_PKT_STRUCT_WIDTH, offset packet width.
- GCID_W, 3*GLOBAL_CELL_ID_WIDTH, packed x/y/z global cell id width.
- LIFE_W, NB_CELL_COUNT_WIDTH, lifetime width.
- CNT_W, 8, TX FIFO occupancy width.
- BP_HI, 200, occupancy at or above which back-pressure asserts.
- BP_LO, 128, occupancy at or below which back-pressure deasserts; BP_LO < BP_HI required.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_src_valid  in  NUM_SRC  per-source FIFO not-empty (FWFT).
- i_src_offset_pkt  in  NUM_SRC*PKT_W  per-source head packet; source k occupies slice k.
- i_src_gcid  in  NUM_SRC*GCID_W  per-source head gcid (sender's frame, unconverted).
- i_src_lifetime  in  NUM_SRC*LIFE_W  per-source head lifetime.
- o_src_rd  out  NUM_SRC  one-hot pop pulse.
- o_remote_valid  out  1  held packet valid to ext node.
- o_remote_offset_pkt  out  PKT_W  held packet.
- o_remote_gcid  out  GCID_W  held gcid.
- o_remote_lifetime  out  LIFE_W  held lifetime.
- o_remote_src_id  out  $clog2(NUM_SRC)  source index of held packet.
- i_remote_ack  in  1  ext node accepted the held packet this cycle.
- i_tx_fifo_count  in  CNT_W  outbound remote TX FIFO occupancy.
- o_remote_buffer_back_pressure  out  1  to ext node.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: every output is 0. State returns to IDLE, rr_ptr = NUM_SRC-1 so source 0 is granted first, and the hold registers clear.
- Reset mid-operation: the held packet is lost, with no pop and no valid. The source FIFO content is untouched.
- States:
  - IDLE: o_remote_valid=0.
  - HOLD: o_remote_valid=1, outputs stable until ack.
- Eligible source k: i_src_valid[k]=1 and its lifetime ≠ 0.
- Grant: first eligible k searching rr_ptr+1, rr_ptr+2, … modulo NUM_SRC. This is combinational from the current inputs.
- Load condition: state==IDLE, or (state==HOLD and i_remote_ack).
- On load with a grant:
  - o_src_rd[k]=1 combinationally in the same cycle.
  - At the clock edge, the hold registers capture slice k and o_remote_src_id=k.
  - rr_ptr becomes k and state becomes HOLD.
- Latency: source valid in cycle t → o_remote_valid in cycle t+1.
- On load with no grant: state becomes IDLE, o_remote_valid=0, data registers cleared.
- Back-to-back: ack plus an eligible source in the same cycle keeps HOLD with the new packet next cycle, giving 1 packet/cycle peak throughput.
- In HOLD without ack: no pop, outputs frozen, rr_ptr frozen.
- i_remote_ack while in IDLE is ignored.
- Zero-lifetime head: whenever a load is permitted, every source with valid=1 and lifetime=0 is popped in that cycle (o_src_rd may then be multi-hot). These packets are discarded and never presented, and they do not move rr_ptr.
- Back-pressure:
  - Registered.
  - Next value = 1 if i_tx_fifo_count ≥ BP_HI; 0 if i_tx_fifo_count ≤ BP_LO; otherwise the previous value.
  - Independent of the arbiter state.
- No arithmetic on gcid. Frame conversion is done downstream in the ext node.

Optional Feature:
- Macro: POS_REMOTE_ARB_STATS_EN.
- When defined, adds:
  - Output port o_grant_cnt (NUM_SRC*32): per-source 32-bit count of presented packets, incremented at grant. It wraps at 2^32.
  - Output port o_drop_cnt (32): count of zero-lifetime discards, summing all sources popped in the same cycle.
  - Output port o_stall_cycles (32): cycles in HOLD without ack.
- All three counters reset to 0.
- When undefined, none of these ports or registers exist and the behaviour is otherwise identical.

Test Plan:
- After reset, sources 0, 3 and 5 are all valid with lifetime 4, and ack is always 1 → grants 0, 3, 5, 0, … on consecutive cycles; one-hot o_src_rd; o_remote_valid continuous from the cycle after the first pop.
- Source 2 valid, ack held 0 for 10 cycles, then 1 → o_remote_valid=1 with stable data for 11 cycles; exactly one pop of source 2; state IDLE afterwards.
- Source 4 head lifetime=0 followed by lifetime=3, ack=1 → first packet popped and never presented; second packet presented with o_remote_src_id=4; o_drop_cnt=1 with the stats feature enabled.
- i_tx_fifo_count ramps 0→255→0 → back-pressure rises the cycle after count=200, stays high for 129..199, falls the cycle after count=128.
- rst asserted while in HOLD with source 6 valid → next cycle all outputs are 0; after release, source 6 is granted again and its head packet is unchanged.
- All seven sources valid continuously, ack random 50% → each source granted within 7 acks of becoming eligible (no starvation); packets per source match FIFO order.
